// File: rtl/pacman_pkg.sv
// Shared constants for the Pac-Man maze blocks: directions, tile codes,
// default maze geometry and the maze_tiles state enum.
package pacman_pkg;
  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [1:0] TILE_WALL = 2'b00;
  localparam logic [1:0] TILE_WKNP = 2'b01;
  localparam logic [1:0] TILE_WKRP = 2'b10;
  localparam logic [1:0] TILE_WKGH = 2'b11;

  localparam int DEF_COLS = 28;
  localparam int DEF_ROWS = 31;

  typedef enum logic {S_RUN = 1'b0, S_CLEARED = 1'b1} mt_state_e;
endpackage

// File: rtl/maze_tiles_if.sv
// Coordinate/neighbour bus between the movement block (master) and the
// maze state store (slave).
interface maze_tiles_if;
  logic [5:0]      xtile;
  logic [5:0]      ytile;
  logic            eat_en;
  logic            level_restart;
  logic [3:0][1:0] tile_info;
  logic            pellet_eaten;
  logic [15:0]     score;
  logic [9:0]      pellets_left;
  logic [7:0]      level;
  logic            level_clear;

  modport master (
    output xtile, ytile, eat_en, level_restart,
    input  tile_info, pellet_eaten, score, pellets_left, level, level_clear
  );
  modport slave (
    input  xtile, ytile, eat_en, level_restart,
    output tile_info, pellet_eaten, score, pellets_left, level, level_clear
  );
endinterface

// File: rtl/maze_rom.sv
// Static maze layout lookup: (column, row) -> 2-bit tile code, purely combinational.
// Horizontal corridors on rows 1/7/19/25, vertical ones on columns 1/6/11/16/21/26.
module maze_rom
  import pacman_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic [5:0] col,
  input  logic [5:0] row,
  output logic [1:0] code
);
  localparam logic [5:0] COLS6      = 6'(COLS);
  localparam logic [5:0] ROWS6      = 6'(ROWS);
  localparam logic [5:0] TUNNEL_ROW = 6'd13;

  logic interior, h_corr, v_corr, start_area, ghost_house;

  always_comb begin
    interior    = (row >= 6'd1) && (row <= ROWS6 - 6'd2) &&
                  (col >= 6'd1) && (col <= COLS6 - 6'd2);
    h_corr      = row inside {6'd1, 6'd7, 6'd19, 6'd25};
    v_corr      = col inside {6'd1, 6'd6, 6'd11, 6'd16, 6'd21, 6'd26};
    start_area  = (row == 6'd25) && (col >= 6'd13) && (col <= 6'd16);
    ghost_house = (row == 6'd15) && (col >= 6'd12) && (col <= 6'd15);

    // Tunnel row runs edge to edge with no pellets; start area is pellet-free
    if (col >= COLS6 || row >= ROWS6)   code = TILE_WALL;
    else if (row == TUNNEL_ROW)         code = TILE_WKNP;
    else if (ghost_house)               code = TILE_WKGH;
    else if (interior && (h_corr || v_corr))
      code = start_area ? TILE_WKNP : TILE_WKRP;
    else                                code = TILE_WALL;
  end
endmodule

// File: rtl/maze_tiles.sv
// Maze state store: neighbour tile lookup, eaten-pellet bitmap, score,
// pellets-remaining and level tracking with a RUN/CLEARED state machine.
module maze_tiles
  import pacman_pkg::*;
#(
  parameter int COLS          = DEF_COLS,
  parameter int ROWS          = DEF_ROWS,
  parameter int TOTAL_PELLETS = 244,
  parameter int PELLET_PTS    = 10
) (
  input  logic        clk60,
  input  logic        reset,
  maze_tiles_if.slave bus
);
  localparam int         XW    = $clog2(COLS);
  localparam int         YW    = $clog2(ROWS);
  localparam logic [5:0] COLS6 = 6'(COLS);
  localparam logic [5:0] ROWS6 = 6'(ROWS);

  logic [5:0] nb_x [4];
  logic [5:0] nb_y [4];
  logic [1:0] tile_w [4];
  logic [1:0] cur_rom;
  logic       cur_ok, cur_hit, eat;

  mt_state_e                 state_q, state_d;
  logic [ROWS-1:0][COLS-1:0] eaten_q, eaten_d;
  logic [15:0]               score_q, score_d;
  logic [9:0]                pellets_left_q, pellets_left_d;
  logic [7:0]                level_q, level_d;
  logic                      pellet_eaten_q, pellet_eaten_d;

  assign cur_ok = (bus.xtile < COLS6) && (bus.ytile < ROWS6);

  // Up from row 0 wraps to 63 and down from the last row lands on ROWS;
  // both are out of range, so the ROM returns WALL without extra gating.
  always_comb begin
    nb_x[DIR_RIGHT] = (bus.xtile == COLS6 - 6'd1) ? 6'd0 : bus.xtile + 6'd1;
    nb_y[DIR_RIGHT] = bus.ytile;
    nb_x[DIR_UP]    = bus.xtile;
    nb_y[DIR_UP]    = bus.ytile - 6'd1;
    nb_x[DIR_DOWN]  = bus.xtile;
    nb_y[DIR_DOWN]  = bus.ytile + 6'd1;
    nb_x[DIR_LEFT]  = (bus.xtile == 6'd0) ? COLS6 - 6'd1 : bus.xtile - 6'd1;
    nb_y[DIR_LEFT]  = bus.ytile;
  end

  for (genvar d = 0; d < 4; d++) begin : g_nb
    logic [1:0] rom_code;
    logic       hit;
    maze_rom #(.COLS(COLS), .ROWS(ROWS)) u_rom (
      .col (nb_x[d]),
      .row (nb_y[d]),
      .code(rom_code)
    );
    // Bitmap index is only meaningful when the ROM reports WKRP (in range)
    assign hit       = eaten_q[nb_y[d][YW-1:0]][nb_x[d][XW-1:0]];
    assign tile_w[d] = !cur_ok                            ? TILE_WALL :
                       (rom_code == TILE_WKRP && hit)     ? TILE_WKNP : rom_code;
  end

  maze_rom #(.COLS(COLS), .ROWS(ROWS)) u_rom_c (
    .col (bus.xtile),
    .row (bus.ytile),
    .code(cur_rom)
  );

  assign cur_hit = eaten_q[bus.ytile[YW-1:0]][bus.xtile[XW-1:0]];
  assign eat     = (state_q == S_RUN) && bus.eat_en &&
                   (cur_rom == TILE_WKRP) && !cur_hit;

  always_comb begin
    state_d        = state_q;
    eaten_d        = eaten_q;
    score_d        = score_q;
    pellets_left_d = pellets_left_q;
    level_d        = level_q;
    pellet_eaten_d = 1'b0;
    if (bus.level_restart) begin
      eaten_d        = '0;
      pellets_left_d = 10'(TOTAL_PELLETS);
      state_d        = S_RUN;
    end else if (eat) begin
      eaten_d[bus.ytile[YW-1:0]][bus.xtile[XW-1:0]] = 1'b1;
      score_d        = (score_q > 16'hFFFF - 16'(PELLET_PTS)) ? 16'hFFFF
                                                              : score_q + 16'(PELLET_PTS);
      pellets_left_d = pellets_left_q - 10'd1;
      pellet_eaten_d = 1'b1;
      if (pellets_left_q == 10'd1) begin
        state_d = S_CLEARED;
        level_d = level_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk60) begin
    if (reset) begin
      state_q        <= S_RUN;
      eaten_q        <= '0;
      score_q        <= '0;
      pellets_left_q <= 10'(TOTAL_PELLETS);
      level_q        <= '0;
      pellet_eaten_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      eaten_q        <= eaten_d;
      score_q        <= score_d;
      pellets_left_q <= pellets_left_d;
      level_q        <= level_d;
      pellet_eaten_q <= pellet_eaten_d;
    end
  end

  assign bus.tile_info    = {tile_w[3], tile_w[2], tile_w[1], tile_w[0]};
  assign bus.pellet_eaten = pellet_eaten_q;
  assign bus.score        = score_q;
  assign bus.pellets_left = pellets_left_q;
  assign bus.level        = level_q;
  assign bus.level_clear  = (state_q == S_CLEARED);
endmodule

// File: tb/tb_maze_tiles.sv
// Bench for maze_tiles: directed neighbour table, multi-cycle eat/restart/clear
// sequences and randomized play, all checked against a drawn-map reference model.
module tb_maze_tiles;
  localparam int W = 0, NP = 1, RP = 2, GH = 3;
  localparam int NC = 28, NR = 31, TOT = 244, PTS = 10;

  logic clk60 = 1'b0;
  logic reset = 1'b1;
  always #5 clk60 = ~clk60;

  maze_tiles_if bus();
  maze_tiles #(.COLS(NC), .ROWS(NR), .TOTAL_PELLETS(TOT), .PELLET_PTS(PTS)) dut (
    .clk60(clk60),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int         x;
    int         y;
    logic [7:0] exp;   // {left, down, up, right}
  } vec_t;

  int layout [NR][NC];
  bit eaten  [NR][NC];
  int px[$], py[$];
  int m_score, m_left, m_level;
  bit m_clr, m_pulse, m_valid;
  int cx, cy;
  bit ce, crl, crs;
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Draw the maze the way a designer would sketch it: walls, corridors, overlays
  task automatic build_layout();
    int hr[4] = '{1, 7, 19, 25};
    int vc[6] = '{1, 6, 11, 16, 21, 26};
    for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) layout[r][c] = W;
    foreach (hr[i]) for (int c = 1; c <= 26; c++) layout[hr[i]][c] = RP;
    foreach (vc[i]) for (int r = 1; r <= 29; r++) layout[r][vc[i]] = RP;
    for (int c = 0; c < NC; c++) layout[13][c] = NP;
    for (int c = 13; c <= 16; c++) layout[25][c] = NP;
    for (int c = 12; c <= 15; c++) layout[15][c] = GH;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (layout[r][c] == RP) begin px.push_back(c); py.push_back(r); end
  endtask

  function automatic int mcode(int x, int y);
    if (x < 0 || x >= NC || y < 0 || y >= NR) return W;
    if (layout[y][x] == RP && eaten[y][x]) return NP;
    return layout[y][x];
  endfunction

  function automatic int exp_tiles(int x, int y);
    int r, u, d, l;
    if (x >= NC || y >= NR) return 0;
    r = mcode((x + 1) % NC, y);
    l = mcode((x + NC - 1) % NC, y);
    u = mcode(x, y - 1);
    d = mcode(x, y + 1);
    return (l << 6) | (d << 4) | (u << 2) | r;
  endfunction

  task automatic model_step();
    m_pulse = 0;
    if (crs) begin
      for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) eaten[r][c] = 0;
      m_score = 0; m_level = 0; m_left = TOT; m_clr = 0; m_valid = 1;
    end else if (crl) begin
      for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) eaten[r][c] = 0;
      m_left = TOT; m_clr = 0;
    end else if (!m_clr && ce && mcode(cx, cy) == RP) begin
      eaten[cy][cx] = 1;
      m_score = (m_score + PTS > 65535) ? 65535 : m_score + PTS;
      m_left--;
      m_pulse = 1;
      if (m_left == 0) begin m_clr = 1; m_level = (m_level + 1) % 256; end
    end
  endtask

  task automatic drive(input int x, input int y, input bit e, input bit rl, input bit rs);
    cx = x; cy = y; ce = e; crl = rl; crs = rs;
    bus.xtile = 6'(x); bus.ytile = 6'(y);
    bus.eat_en = e; bus.level_restart = rl; reset = rs;
    #1;
    if (m_valid) begin
      chk("tile_info",    32'(bus.tile_info),    32'(exp_tiles(x, y)));
      chk("pellet_eaten", 32'(bus.pellet_eaten), 32'(m_pulse));
      chk("score",        32'(bus.score),        32'(m_score));
      chk("pellets_left", 32'(bus.pellets_left), 32'(m_left));
      chk("level",        32'(bus.level),        32'(m_level));
      chk("level_clear",  32'(bus.level_clear),  32'(m_clr));
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk60);
    #1;
  endtask

  task automatic cyc(input int x, input int y, input bit e, input bit rl, input bit rs);
    drive(x, y, e, rl, rs);
    step();
  endtask

  vec_t vt[14];
  int   pulses, total, idx;

  initial begin
    bus.xtile = '0; bus.ytile = '0; bus.eat_en = 1'b0; bus.level_restart = 1'b0;
    build_layout();
    vt = '{'{14, 25, 8'h41}, '{ 0, 13, 8'h41}, '{27, 13, 8'h41}, '{ 1,  0, 8'h20},
           '{ 6,  1, 8'hA2}, '{ 5, 62, 8'h00}, '{30,  5, 8'h00}, '{11, 30, 8'h08},
           '{13, 14, 8'h34}, '{16, 24, 8'h18}, '{26, 29, 8'h08}, '{ 0, 28, 8'h02},
           '{63, 63, 8'h00}, '{27,  1, 8'h80}};

    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    drive(14, 25, 0, 0, 0);
    chk("rst_score", 32'(bus.score), 0);
    chk("rst_pellets_left", 32'(bus.pellets_left), TOT);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_level_clear", 32'(bus.level_clear), 0);
    chk("rst_pellet_eaten", 32'(bus.pellet_eaten), 0);
    step();

    foreach (vt[i]) begin
      drive(vt[i].x, vt[i].y, 0, 0, 0);
      chk($sformatf("vec%0d_tile_info", i), 32'(bus.tile_info), 32'(vt[i].exp));
      step();
    end

    // Out-of-range current tile with eat_en must not eat
    cyc(5, 62, 1, 0, 0);
    chk("oor_no_eat", 32'(bus.pellet_eaten), 0);

    // Dwell on a pellet for three cycles: exactly one eat
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, k < 3, 0, 0);
      pulses += int'(bus.pellet_eaten);
    end
    chk("single_pulse", 32'(pulses), 1);
    chk("eat_score", 32'(bus.score), 10);
    chk("eat_pellets_left", 32'(bus.pellets_left), 243);
    drive(2, 1, 0, 0, 0);
    chk("eaten_reads_wknp", 32'(bus.tile_info[3]), NP);
    step();

    // Restart wins over a simultaneous eat
    cyc(2, 1, 1, 1, 0);
    chk("restart_no_pulse", 32'(bus.pellet_eaten), 0);
    chk("restart_score_kept", 32'(bus.score), 10);
    chk("restart_pellets_left", 32'(bus.pellets_left), TOT);
    drive(2, 1, 0, 0, 0);
    chk("restart_restores_pellet", 32'(bus.tile_info[3]), RP);
    step();

    // Clear the whole level from a fresh reset
    cyc(0, 0, 0, 0, 1);
    for (int j = 0; j < px.size(); j++) cyc(px[j], py[j], 1, 0, 0);
    chk("clear_level_clear", 32'(bus.level_clear), 1);
    chk("clear_level", 32'(bus.level), 1);
    chk("clear_pellets_left", 32'(bus.pellets_left), 0);
    chk("clear_score", 32'(bus.score), 2440);
    cyc(1, 1, 1, 0, 0);
    chk("cleared_no_eat", 32'(bus.pellet_eaten), 0);
    cyc(0, 0, 0, 1, 0);
    chk("rerun_level_clear", 32'(bus.level_clear), 0);
    chk("rerun_pellets_left", 32'(bus.pellets_left), TOT);
    chk("rerun_score", 32'(bus.score), 2440);
    chk("rerun_level", 32'(bus.level), 1);

    // Keep eating across levels up to the saturation boundary
    total = TOT; idx = 0;
    while (total < 6553) begin
      cyc(px[idx], py[idx], 1, 0, 0);
      total++; idx++;
      if (idx == px.size()) begin cyc(0, 0, 0, 1, 0); idx = 0; end
    end
    chk("score_near_max", 32'(bus.score), 65530);
    cyc(px[idx], py[idx], 1, 0, 0); idx++;
    chk("score_saturates", 32'(bus.score), 65535);
    cyc(px[idx], py[idx], 1, 0, 0);
    chk("score_stays_max", 32'(bus.score), 65535);

    // Mid-level reset returns everything to power-up values
    cyc(0, 0, 0, 0, 1);
    chk("midreset_score", 32'(bus.score), 0);
    chk("midreset_level", 32'(bus.level), 0);
    chk("midreset_pellets_left", 32'(bus.pellets_left), TOT);

    for (int k = 0; k < 1500; k++) begin
      int x, y, j;
      bit e, rl, rs;
      if ($urandom_range(1, 0) == 1) begin
        j = $urandom_range(TOT - 1, 0); x = px[j]; y = py[j];
      end else begin
        x = $urandom_range(31, 0);
        y = ($urandom_range(3, 0) == 0) ? $urandom_range(63, 60) : $urandom_range(31, 0);
      end
      e  = ($urandom_range(3, 0) != 0);
      rl = ($urandom_range(63, 0) == 0);
      rs = ($urandom_range(499, 0) == 0);
      cyc(x, y, e, rl, rs);
    end
    drive(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/maze_tiles.md
# maze_tiles

Maze state store that sits directly upstream of the Pac-Man movement block. It takes Pac-Man's current tile coordinates and returns the 2-bit tile codes of the four neighbouring tiles, indexed by direction. It also tracks which pellets have been eaten, maintains score and pellets-remaining counters, and flags level clear. The static layout comes from a ROM; eaten pellets are held in a one-bit-per-tile bitmap, so a level restart takes a single cycle.

## Interface

Parameters:
- COLS, 28, maze width in tiles
- ROWS, 31, maze height in tiles
- TOTAL_PELLETS, 244, number of WKRP tiles in the ROM layout
- PELLET_PTS, 10, score added per pellet

Ports:
- clk60  input  1  60 Hz game clock; the only clock
- reset  input  1  synchronous, active-high; clears score, level and bitmap
- xtile  input  6  Pac-Man tile column; driven from the movement block's curr_xtile
- ytile  input  6  Pac-Man tile row; driven from curr_ytile; may wrap to 60–63 near the top
- eat_en  input  1  high while the game is in its NORMAL state
- level_restart  input  1  clears the bitmap and reloads pellets; score is kept
- tile_info[0:3]  output  2 each  neighbour codes: [0]=right, [1]=up, [2]=down, [3]=left
- pellet_eaten  output  1  one-cycle pulse per pellet consumed
- score  output  16  binary score, saturating
- pellets_left  output  10  pellets remaining in the current level
- level  output  8  number of levels cleared, wraps at 255
- level_clear  output  1  high while in state CLEARED

## Operation

- Tile codes: WALL=00, WKNP=01, WKRP=10, WKGH=11.
- Effective code of a tile:
  - WALL if the column is ≥ COLS or the row is ≥ ROWS.
  - Otherwise the ROM code, except that ROM WKRP with its eaten bit set reads as WKNP.
- Neighbour addressing:
  - Left of column 0 is column COLS-1, and right of column COLS-1 is column 0 (tunnel).
  - Up from row 0 and down from row ROWS-1 read WALL.
  - If the current tile is out of range, every neighbour reads WALL.
- FSM states: RUN (reset state) and CLEARED.
  - RUN: a pellet is eaten when eat_en=1 and the current tile's effective code is WKRP. On that clock edge:
    - the eaten bit is set;
    - score += PELLET_PTS, saturating at 16'hFFFF;
    - pellets_left decrements;
    - pellet_eaten pulses.
  - RUN → CLEARED: the eat that takes pellets_left from 1 to 0; level increments on the same edge.
  - CLEARED: eating is inhibited. level_restart → RUN.
- Effect of level_restart (in either state): all eaten bits cleared, pellets_left=TOTAL_PELLETS, state=RUN. score and level are unchanged. A restart during RUN restarts the level mid-play.
- Priority: reset > level_restart > eat. An eat in the same cycle as level_restart is dropped, with no score and no pulse.

## Timing

- tile_info is combinational from xtile/ytile and the registered bitmap. It is valid in the same cycle as the coordinates, so the movement block sees fresh neighbours each tick.
- The eaten bit is registered. The tile reads WKNP from the cycle after the eat, so a tile cannot be double-counted even if Pac-Man stays on it.
- pellet_eaten, score, pellets_left and level_clear all update on the eat edge and are visible one cycle after the eat condition.
- Values after reset: state RUN, score=0, level=0, pellets_left=TOTAL_PELLETS, bitmap all zero, pellet_eaten=0, level_clear=0.
- Reset asserted mid-level behaves identically to the power-up reset.

## Structure

- pacman_pkg holds:
  - the direction constants (RIGHT=00, UP=01, DOWN=10, LEFT=11);
  - the tile-code constants;
  - the default COLS and ROWS;
  - the maze_tiles state enum.
- Sub-module maze_rom: a combinational single-address layout lookup (column, row → 2-bit code). It is instantiated five times: the centre tile plus four neighbours.
- The bitmap is a COLS×ROWS flop array. A block RAM is not used, because single-cycle clear is required.

## Test plan

- Reset, then drive xtile=14, ytile=25 with eat_en=0 → tile_info matches the ROM neighbours; score=0; pellets_left=244; level_clear=0.
- Place Pac-Man on a WKRP tile with eat_en=1 for 3 cycles → exactly one pellet_eaten pulse; score=10; pellets_left=243; the tile reads WKNP from a neighbour position.
- Drive xtile=0 on the tunnel row → tile_info[3] equals the code at column 27; on row 0, tile_info[1]=WALL; ytile=62 → all four neighbours read WALL, no eat.
- Eat all 244 pellets → on the last eat, level_clear=1 and level=1; further eats are ignored. Then pulse level_restart → state RUN, pellets_left=244, score=2440 retained.
- Assert level_restart together with an eat on a WKRP tile → no pulse, score unchanged, pellets_left=244.
- Preload score near the limit by forcing 65530, then eat → score=65535, with no wrap.
